// File: rtl/lvds_tx_sequencer.sv
// -----------------------------------------------------------------------------
// lvds_tx_sequencer
//
// Slot/timing controller for a 7:1 three-lane pixel encoder. Runs on the serial
// bit clock: one pixel slot lasts seven clocks, marked by a one-hot phase ring.
// On every slot boundary the raster position advances and the video timing
// plus the 18-bit RGB word for the new position are registered, so they stay
// stable for the whole slot while the encoder shifts them out.
//
// Optional build macro: LVDS_TX_TEST_PATTERN_EN
//   Defined   : upstream source ignored, active area shows 8 vertical colour
//               bars (white, yellow, cyan, green, magenta, red, blue, black).
//   Undefined : pixels are pulled from the upstream ready/valid source.
//
// Ports
//   clk             bit clock (7x pixel rate)
//   rst_n           asynchronous active-low reset
//   en              run enable; low freezes every register
//   pix_valid       upstream pixel available
//   pix_rgb[17:0]   {R[5:0],G[5:0],B[5:0]} from upstream
//   pix_ready       combinational; pixel taken at this edge if pix_valid
//   phase[6:0]      one-hot slot phase to encoder
//   HS, VS, DE      registered video timing for the current slot
//   R, G, B [5:0]   registered colour for the current slot
//   frame_start     high for the first enabled cycle of pixel (0,0)
//   clear_underflow synchronous clear of underflow
//   underflow       sticky: an active slot found no pixel waiting
// -----------------------------------------------------------------------------
module lvds_tx_sequencer #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        pix_valid,
   input  logic [17:0] pix_rgb,
   output logic        pix_ready,
   output logic [6:0]  phase,
   output logic        HS,
   output logic        VS,
   output logic        DE,
   output logic [5:0]  R,
   output logic [5:0]  G,
   output logic [5:0]  B,
   output logic        frame_start,
   input  logic        clear_underflow,
   output logic        underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   // Window bounds kept at 32 bits: HS_END/VS_END may equal the total and
   // would not fit the counter width.
   localparam logic [31:0] HA       = 32'(H_ACTIVE);
   localparam logic [31:0] VA       = 32'(V_ACTIVE);
   localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] hcnt;
   logic [HW-1:0] h_nxt;
   logic [VW-1:0] vcnt;
   logic [VW-1:0] v_nxt;
   logic          nxt_active;
   logic          nxt_hs;
   logic          nxt_vs;
   logic          uf_set;
   logic [17:0]   rgb_nxt;

   // Position the raster moves to at the next slot boundary.
   always_comb begin
      h_nxt = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
      v_nxt = vcnt;
      if (hcnt == H_LAST) begin
         v_nxt = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end
      nxt_active = (32'(h_nxt) < HA) && (32'(v_nxt) < VA);
      nxt_hs     = (32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END);
      nxt_vs     = (32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END);
   end

`ifdef LVDS_TX_TEST_PATTERN_EN
   logic [2:0] bar;
   logic       unused_src;

   assign unused_src = ^{pix_valid, pix_rgb};

   // bar bit2 clears green, bit1 clears red, bit0 clears blue, which yields
   // white, yellow, cyan, green, magenta, red, blue, black left to right.
   always_comb begin
      bar       = 3'((32'(h_nxt) * 32'd8) / HA);
      pix_ready = 1'b0;
      uf_set    = 1'b0;
      rgb_nxt   = '0;
      if (nxt_active) begin
         rgb_nxt = {{6{~bar[1]}}, {6{~bar[2]}}, {6{~bar[0]}}};
      end
   end
`else
   // Handshake: pix_ready is offered only in the boundary cycle (en=1,
   // phase[6]=1) of a slot whose next position is active. A pixel transfers
   // on the clock edge where pix_ready && pix_valid are both high; pix_rgb
   // then lands in R/G/B for that slot. pix_ready never depends on pix_valid,
   // and the source is never popped during blanking. A ready with no valid
   // sends black for the slot and raises underflow.
   always_comb begin
      pix_ready = en & phase[6] & nxt_active;
      uf_set    = pix_ready & ~pix_valid;
      rgb_nxt   = (pix_ready & pix_valid) ? pix_rgb : '0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= 7'b0000001;
         hcnt        <= H_LAST;
         vcnt        <= V_LAST;
         DE          <= 1'b0;
         HS          <= ~HS_POL;
         VS          <= ~VS_POL;
         R           <= '0;
         G           <= '0;
         B           <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else if (en) begin
         phase       <= {phase[5:0], phase[6]};
         // Registered so it coincides with the phase=0000001 cycle of (0,0).
         frame_start <= phase[6] && (h_nxt == '0) && (v_nxt == '0);
         // Set has priority over a simultaneous clear.
         underflow   <= uf_set | (underflow & ~clear_underflow);
         if (phase[6]) begin
            hcnt      <= h_nxt;
            vcnt      <= v_nxt;
            DE        <= nxt_active;
            HS        <= nxt_hs ? HS_POL : ~HS_POL;
            VS        <= nxt_vs ? VS_POL : ~VS_POL;
            {R, G, B} <= rgb_nxt;
         end
      end
   end

endmodule

// File: tb/tb_lvds_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lvds_tx_sequencer
//
// Self-checking bench for lvds_tx_sequencer with a small 8x5 (or 12x5 with
// the colour-bar build) raster. Inputs change on the falling edge; outputs
// are sampled 4 ns later, one ns before the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lvds_tx_sequencer;

`ifdef LVDS_TX_TEST_PATTERN_EN
   localparam int HA = 8;
`else
   localparam int HA = 4;
`endif
   localparam int HFP   = 1;
   localparam int HSY   = 2;
   localparam int HBP   = 1;
   localparam int VA    = 2;
   localparam int VFP   = 1;
   localparam int VSY   = 1;
   localparam int VBP   = 1;
   localparam int HT    = HA + HFP + HSY + HBP;
   localparam int VT    = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT * 7;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        pix_valid = 1'b0;
   logic [17:0] pix_rgb = '0;
   logic        clear_underflow = 1'b0;
   logic        pix_ready;
   logic [6:0]  phase;
   logic        HS, VS, DE;
   logic [5:0]  R, G, B;
   logic        frame_start;
   logic        underflow;

   always #5 clk = ~clk;

   lvds_tx_sequencer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
      .phase(phase), .HS(HS), .VS(VS), .DE(DE),
      .R(R), .G(G), .B(B),
      .frame_start(frame_start),
      .clear_underflow(clear_underflow), .underflow(underflow)
   );

   int   total = 0;
   int   bad = 0;
   int   c = 0;          // enabled edges since reset release
   logic en_prev = 1'b0;

   // ---------------- reference timing ----------------
   // Expected outputs after cc enabled edges from reset release.
   function automatic void model(input int cc, output logic [6:0] ph,
                                 output logic de, output logic hs,
                                 output logic vs, output logic fs);
      int s, h, v;
      ph = 7'(1 << (cc % 7));
      if (cc < 7) begin
         de = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0;
      end else begin
         s  = (cc - 7) / 7;
         h  = s % HT;
         v  = (s / HT) % VT;
         de = (h < HA) && (v < VA);
         hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
         vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
         fs = ((cc - 7) % FRAME) == 0;
      end
   endfunction

   // pix_ready expected in the cycle after cc edges (boundary into active).
   function automatic logic model_rdy(input int cc);
      int s;
      if (cc % 7 != 6) return 1'b0;
      s = (cc - 6) / 7;
      return ((s % HT) < HA) && (((s / HT) % VT) < VA);
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic en_v, input logic valid_v,
                       input logic [17:0] rgb_v, input logic clr_v);
      @(negedge clk);
      if (en_prev && rst_n) c++;
      en              = en_v;
      pix_valid       = valid_v;
      pix_rgb         = rgb_v;
      clear_underflow = clr_v;
      en_prev         = en_v;
      #4;
   endtask

   // ---------------- scoreboard ----------------
   logic [17:0] exp_q[$];
   logic        pend = 1'b0;

   initial begin
      logic [17:0] exp_rgb;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
         end else begin
            if (pend) begin
               pend = 1'b0;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL sb_empty: slot started with no expected pixel queued (c=%0d)", c);
               end else begin
                  exp_rgb = exp_q.pop_front();
                  if ({DE, R, G, B} !== {1'b1, exp_rgb}) begin
                     bad++;
                     $display("FAIL sb_pixel: c=%0d got DE=%b rgb=%h, want DE=1 rgb=%h",
                              c, DE, {R, G, B}, exp_rgb);
                  end
               end
            end
            if (pix_ready === 1'b1) begin
               exp_q.push_back(pix_valid ? pix_rgb : 18'h0);
               pend = 1'b1;
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; pix_valid = 1'b1; pix_rgb = 18'h3F000;
      repeat (2) @(negedge clk);
      #4;
      total++;
      if (phase !== 7'b0000001) begin
         bad++; $display("FAIL rst_phase: got %b want 0000001", phase);
      end
      total++;
      if ({DE, HS, VS} !== 3'b000) begin
         bad++; $display("FAIL rst_timing: got DE/HS/VS=%b want 000", {DE, HS, VS});
      end
      total++;
      if ({R, G, B} !== 18'h0) begin
         bad++; $display("FAIL rst_rgb: got %h want 0", {R, G, B});
      end
      total++;
      if ({pix_ready, frame_start, underflow} !== 3'b000) begin
         bad++; $display("FAIL rst_flags: got rdy/fs/uf=%b want 000",
                         {pix_ready, frame_start, underflow});
      end
   endtask

`ifdef LVDS_TX_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [6:0]  ph;
      logic        de, hs, vs, fs;
      logic [17:0] bar_rgb [8];
      int          h;
      bar_rgb[0] = {6'd63, 6'd63, 6'd63};
      bar_rgb[1] = {6'd63, 6'd63, 6'd0};
      bar_rgb[2] = {6'd0,  6'd63, 6'd63};
      bar_rgb[3] = {6'd0,  6'd63, 6'd0};
      bar_rgb[4] = {6'd63, 6'd0,  6'd63};
      bar_rgb[5] = {6'd63, 6'd0,  6'd0};
      bar_rgb[6] = {6'd0,  6'd0,  6'd63};
      bar_rgb[7] = {6'd0,  6'd0,  6'd0};
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; pix_valid = 1'b1; en_prev = 1'b1; c = 0;
      #4;
      while (c < 7 + 7 * HT + 7) begin
         step(1'b1, 1'b1, 18'($urandom), 1'b0);
         model(c, ph, de, hs, vs, fs);
         total++;
         if ({phase, DE, HS, VS} !== {ph, de, hs, vs}) begin
            bad++; $display("FAIL tp_timing: c=%0d got %b want %b", c,
                            {phase, DE, HS, VS}, {ph, de, hs, vs});
         end
         total++;
         if ({pix_ready, underflow} !== 2'b00) begin
            bad++; $display("FAIL tp_ready: c=%0d got rdy/uf=%b want 00", c,
                            {pix_ready, underflow});
         end
         if (de) begin
            h = ((c - 7) / 7) % HT;
            total++;
            if ({R, G, B} !== bar_rgb[(h * 8) / HA]) begin
               bad++; $display("FAIL tp_bar: c=%0d h=%0d got %h want %h", c, h,
                               {R, G, B}, bar_rgb[(h * 8) / HA]);
            end
         end
      end
   endtask
`else
   task automatic test_startup();
      logic [6:0] ph;
      logic       de, hs, vs, fs;
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; pix_valid = 1'b1; pix_rgb = 18'h3F000;
      clear_underflow = 1'b0; en_prev = 1'b1; c = 0;
      #4;
      for (int i = 0; i <= 7; i++) begin
         if (i > 0) step(1'b1, 1'b1, 18'h3F000, 1'b0);
         model(c, ph, de, hs, vs, fs);
         total++;
         if (phase !== ph) begin
            bad++; $display("FAIL start_phase: c=%0d got %b want %b", c, phase, ph);
         end
         total++;
         if (pix_ready !== (c == 6)) begin
            bad++; $display("FAIL start_ready: c=%0d got %b want %b", c, pix_ready, (c == 6));
         end
      end
      total++;
      if ({DE, R, G, B, frame_start} !== {1'b1, 6'd63, 6'd0, 6'd0, 1'b1}) begin
         bad++; $display("FAIL start_pix: got DE=%b R=%0d G=%0d B=%0d fs=%b want 1 63 0 0 1",
                         DE, R, G, B, frame_start);
      end
   endtask

   task automatic test_full_frame();
      logic [6:0] ph;
      logic       de, hs, vs, fs;
      int         xfers = 0;
      int         fs_cnt = 0;
      while (c < 2 * FRAME + 20) begin
         step(1'b1, 1'b1, 18'($urandom), 1'b0);
         model(c, ph, de, hs, vs, fs);
         total++;
         if ({phase, DE, HS, VS, frame_start} !== {ph, de, hs, vs, fs}) begin
            bad++; $display("FAIL ff_timing: c=%0d got ph/DE/HS/VS/fs=%b want %b", c,
                            {phase, DE, HS, VS, frame_start}, {ph, de, hs, vs, fs});
         end
         total++;
         if (pix_ready !== model_rdy(c)) begin
            bad++; $display("FAIL ff_ready: c=%0d got %b want %b", c, pix_ready, model_rdy(c));
         end
         if (c >= FRAME + 6 && c < 2 * FRAME + 6 && pix_ready === 1'b1) xfers++;
         if (c >= FRAME + 7 && c < 2 * FRAME + 7 && frame_start === 1'b1) fs_cnt++;
      end
      total++;
      if (xfers != HA * VA) begin
         bad++; $display("FAIL ff_xfers: got %0d transfers per frame want %0d", xfers, HA * VA);
      end
      total++;
      if (fs_cnt != 1) begin
         bad++; $display("FAIL ff_fs_count: got %0d frame_start per frame want 1", fs_cnt);
      end
   endtask

   task automatic test_underflow();
      int t = 7 + 7 * 2 - 1;   // boundary into (2,0)
      while (t <= c) t += FRAME;
      while (c + 1 < t) step(1'b1, 1'b1, 18'($urandom), 1'b0);
      step(1'b1, 1'b0, 18'h2AAAA, 1'b0);
      total++;
      if (pix_ready !== 1'b1) begin
         bad++; $display("FAIL uf_ready: c=%0d got %b want 1", c, pix_ready);
      end
      step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if ({DE, R, G, B} !== {1'b1, 18'h0}) begin
         bad++; $display("FAIL uf_slot: got DE=%b rgb=%h want DE=1 rgb=0", DE, {R, G, B});
      end
      total++;
      if (underflow !== 1'b1) begin
         bad++; $display("FAIL uf_set: got %b want 1", underflow);
      end
      repeat (20) step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if (underflow !== 1'b1) begin
         bad++; $display("FAIL uf_sticky: got %b want 1", underflow);
      end
      step(1'b1, 1'b1, 18'($urandom), 1'b1);
      step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if (underflow !== 1'b0) begin
         bad++; $display("FAIL uf_clear: got %b want 0", underflow);
      end
      // starve and clear in the same cycle
      while (!model_rdy(c + 1)) step(1'b1, 1'b1, 18'($urandom), 1'b0);
      step(1'b1, 1'b0, 18'($urandom), 1'b1);
      step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if (underflow !== 1'b1) begin
         bad++; $display("FAIL uf_set_wins: got %b want 1", underflow);
      end
      step(1'b1, 1'b1, 18'($urandom), 1'b1);
      step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if (underflow !== 1'b0) begin
         bad++; $display("FAIL uf_clear2: got %b want 0", underflow);
      end
   endtask

   task automatic test_en_freeze();
      logic [6:0]  ph;
      logic        de, hs, vs, fs;
      logic [17:0] held;
      forever begin
         model(c + 1, ph, de, hs, vs, fs);
         if (((c + 1) % 7 == 3) && de) break;
         step(1'b1, 1'b1, 18'($urandom), 1'b0);
      end
      held = {R, G, B};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 18'($urandom), 1'b0);
         model(c, ph, de, hs, vs, fs);
         total++;
         if ({phase, HS, VS, DE, R, G, B} !== {ph, hs, vs, de, held}) begin
            bad++; $display("FAIL frz_hold: i=%0d got ph=%b hs/vs/de=%b rgb=%h want ph=%b %b rgb=%h",
                            i, phase, {HS, VS, DE}, {R, G, B}, ph, {hs, vs, de}, held);
         end
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 18'($urandom), 1'b0);
         model(c, ph, de, hs, vs, fs);
         total++;
         if (phase !== ph) begin
            bad++; $display("FAIL frz_resume: i=%0d got ph=%b want %b", i, phase, ph);
         end
         if (c % 7 != 0) begin
            total++;
            if ({DE, R, G, B} !== {1'b1, held}) begin
               bad++; $display("FAIL frz_slot: i=%0d got DE=%b rgb=%h want 1 %h",
                               i, DE, {R, G, B}, held);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int t = 7 + 7 * (HT + 2) - 1;   // boundary into (2,1)
      int first = -1;
      while (t <= c) t += FRAME;
      while (c + 1 < t) step(1'b1, 1'b1, 18'($urandom), 1'b0);
      step(1'b1, 1'b0, 18'($urandom), 1'b0);
      repeat (3) step(1'b1, 1'b1, 18'($urandom), 1'b0);
      total++;
      if ({DE, underflow} !== 2'b11) begin
         bad++; $display("FAIL rst_pre: got DE/uf=%b want 11", {DE, underflow});
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({phase, DE, HS, VS} !== {7'b0000001, 3'b000}) begin
         bad++; $display("FAIL rst_mid_timing: got %b want 0000001000", {phase, DE, HS, VS});
      end
      total++;
      if ({R, G, B, pix_ready, frame_start, underflow} !== 21'h0) begin
         bad++; $display("FAIL rst_mid_data: got rgb=%h rdy/fs/uf=%b want 0 000",
                         {R, G, B}, {pix_ready, frame_start, underflow});
      end
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; pix_valid = 1'b1; en_prev = 1'b1; c = 0;
      #4;
      for (int i = 0; i < 20; i++) begin
         if (frame_start === 1'b1 && first < 0) first = c;
         step(1'b1, 1'b1, 18'($urandom), 1'b0);
      end
      total++;
      if (first != 7) begin
         bad++; $display("FAIL rst_fs: first frame_start after %0d enabled cycles want 7", first);
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
`ifdef LVDS_TX_TEST_PATTERN_EN
      test_pattern();
`else
      test_startup();
      test_full_frame();
      test_underflow();
      test_en_freeze();
      test_mid_reset();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200 us");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lvds_tx_sequencer.md
Name: lvds_tx_sequencer

Overview:
- Controller for the 7:1 three-lane pixel encoder.
- Runs at the serial bit clock. Produces the one-hot 7-phase slot select, the video timing (HS/VS/DE) and the registered 18-bit RGB word for the encoder.
- Pulls pixels from an upstream source with a ready/valid handshake.
- Sits between the frame/pixel source and the encoder.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, HS width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, VS width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, HS level while in sync
- VS_POL, 1, VS level while in sync

Ports:
- clk  in  1  bit clock (7x pixel rate)
- rst_n  in  1  async active-low reset
- en  in  1  run enable; low freezes all state
- pix_valid  in  1  upstream pixel available
- pix_rgb  in  18  {R[5:0],G[5:0],B[5:0]}
- pix_ready  out  1  pixel accepted this cycle if pix_valid
- phase  out  7  one-hot slot phase to encoder
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- DE  out  1  data enable
- R  out  6  red to encoder
- G  out  6  green to encoder
- B  out  6  blue to encoder
- frame_start  out  1  one-cycle pulse at first cycle of pixel (0,0)
- clear_underflow  in  1  sync clear of underflow flag
- underflow  out  1  sticky: active pixel needed but pix_valid low

Behaviour:
- Reset (async, rst_n=0):
  - phase=7'b0000001; DE=0; R=G=B=0; HS=~HS_POL; VS=~VS_POL.
  - pix_ready=0; frame_start=0; underflow=0.
  - Internal position: hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Counter widths are $clog2 of the totals.
- Phase ring:
  - Each clk with en=1, phase rotates left (bit6 wraps to bit0).
  - en=0 holds phase, counters and all outputs. Deassertion mid-slot is legal; the slot resumes where it stopped.
- Slot boundary = cycle with en=1 and phase[6]=1. On that edge:
  - Position advances: hcnt+1, wrapping at H_TOTAL-1 to 0 with vcnt+1; vcnt wraps at V_TOTAL-1 to 0.
  - HS/VS/DE/R/G/B are registered for the new position and stay stable for the full 7-cycle slot.
- Timing, per position:
  - DE=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - HS=HS_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VS=VS_POL iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Handshake:
  - pix_ready is combinational. It is 1 only in the boundary cycle and only when the next position is active.
  - Transfer when pix_ready && pix_valid; pix_rgb is loaded into R/G/B.
  - If pix_ready && !pix_valid: R=G=B=0 for that slot, DE still 1, underflow set.
  - The source is never popped during blanking.
- frame_start = 1 for exactly the first enabled cycle of position (0,0), i.e. the cycle where phase=0000001.
- Blanking slots: R=G=B=0.
- underflow is sticky until clear_underflow=1 (synchronous). A simultaneous set and clear leaves it set.
- Startup: after reset release with en=1, the 6th cycle has phase=1000000 and pix_ready=1. The 7th edge enters (0,0) with frame_start=1.
- Reset mid-frame aborts immediately to the reset state; no partial-pixel recovery.

Optional Feature:
- Macro: LVDS_TX_TEST_PATTERN_EN.
- When defined:
  - Pixel source is ignored; pix_ready is held 0 and underflow never sets.
  - Active pixels carry 8 vertical colour bars, bar=(hcnt*8)/H_ACTIVE.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Components are 63 or 0.
- When not defined: normal handshake path as above.

Test Plan:
- Bench params for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1.
- Reset, en=1, pix_valid=1, pix_rgb=18'h3F000 → phase walks 0000001..1000000 one-hot; pix_ready=1 at cycle 6. Cycle 7: DE=1, R=63, G=0, B=0, frame_start=1.
- Full frame with pix_valid=1 → exactly 8 transfers per frame. DE high for hcnt 0-3 in lines 0-1. HS=1 for hcnt 5-6. VS=1 only on line 3. frame_start once per 280 cycles.
- pix_valid=0 at the boundary into hcnt=2, line 0 → that slot has DE=1, RGB=0; underflow=1 and held. clear_underflow pulse → 0.
- en dropped for 5 cycles at phase=0001000 → phase, HS/VS/DE/RGB frozen. Resume completes the slot in the remaining 3 enabled cycles.
- rst_n pulsed low mid-line 1 → outputs return to reset values immediately. After release, the first frame_start occurs 7 enabled cycles later.
- With LVDS_TX_TEST_PATTERN_EN and H_ACTIVE=8 → active pixels give RGB (63,63,63), (63,63,0), (0,63,63), (0,63,0), (63,0,63), (63,0,0), (0,0,63), (0,0,0); pix_ready stays 0.
